// File: rtl/apple1_bus_ctrl_if.sv
// rtl/apple1_bus_ctrl_if.sv - CPU / memory / PIA bus bundle for the Apple-1 bus controller
//
// Purpose : groups the CPU-side bus and the ROM, RAM and PIA device ports.
// Modports: slave  - the bus controller (decodes the CPU bus, drives the device strobes)
//           master - the surroundings (CPU core and device models)
// Signals : cpu_addr/cpu_we/cpu_dout/cpu_din/cpu_clken  CPU side
//           rom_addr/rom_dout                           registered ROM
//           ram_addr/ram_din/ram_we/ram_dout            main RAM
//           pia_rs/pia_din/pia_we/pia_rd/pia_dout       keyboard/display PIA
interface apple1_bus_ctrl_if #(
    parameter int RAM_AW = 13
);
    logic [15:0]       cpu_addr;
    logic              cpu_we;
    logic [7:0]        cpu_dout;
    logic [7:0]        cpu_din;
    logic              cpu_clken;

    logic [7:0]        rom_addr;
    logic [7:0]        rom_dout;

    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_din;
    logic              ram_we;
    logic [7:0]        ram_dout;

    logic [1:0]        pia_rs;
    logic [7:0]        pia_din;
    logic              pia_we;
    logic              pia_rd;
    logic [7:0]        pia_dout;

    modport slave (
        input  cpu_addr, cpu_we, cpu_dout, rom_dout, ram_dout, pia_dout,
        output cpu_din, cpu_clken, rom_addr, ram_addr, ram_din, ram_we,
               pia_rs, pia_din, pia_we, pia_rd
    );

    modport master (
        output cpu_addr, cpu_we, cpu_dout, rom_dout, ram_dout, pia_dout,
        input  cpu_din, cpu_clken, rom_addr, ram_addr, ram_din, ram_we,
               pia_rs, pia_din, pia_we, pia_rd
    );
endinterface

// File: rtl/apple1_bus_ctrl.sv
// rtl/apple1_bus_ctrl.sv - Apple-1 CPU bus controller: clock enable, address decode, read-data alignment
//
// Purpose : divides clk into a one-clk CPU clock enable, decodes the CPU address into
//           RAM / PIA / ROM / unmapped regions, gates the write and PIA-read strobes
//           with the clock enable and registers the read data returned to the CPU.
// Ports   : clk   - system clock
//           rst_n - asynchronous active-low reset
//           bus   - apple1_bus_ctrl_if.slave (CPU side plus ROM, RAM and PIA ports)
module apple1_bus_ctrl #(
    parameter int         CLK_DIV  = 25,
    parameter int         RAM_AW   = 13,
    parameter logic [7:0] OPEN_BUS = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    apple1_bus_ctrl_if.slave  bus
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_ROM  = 2'd2,
        SEL_PIA  = 2'd3
    } sel_e;

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          cpu_clken_q, cpu_clken_d;
    sel_e          sel_q, sel_d;
    logic [7:0]    cpu_din_q, cpu_din_d;
    sel_e          dec;

    // Region decode from the live address; the regions never overlap.
    always_comb begin
        dec = SEL_NONE;
        if (bus.cpu_addr[15:RAM_AW] == '0) begin
            dec = SEL_RAM;
        end else if (bus.cpu_addr[15:4] == 12'hD01) begin
            dec = SEL_PIA;
        end else if (bus.cpu_addr[15:8] == 8'hFF) begin
            dec = SEL_ROM;
        end
    end

    always_comb begin
        div_cnt_d   = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + CW'(1);
        // Registered enable lines up with the counter: high while div_cnt == CLK_DIV-1.
        cpu_clken_d = (div_cnt_d == DIV_LAST);
        // sel_q lags the address by one clk, matching the device read latency,
        // so the mux below picks the device whose data is actually on its port.
        sel_d       = dec;
        unique case (sel_q)
            SEL_RAM: cpu_din_d = bus.ram_dout;
            SEL_ROM: cpu_din_d = bus.rom_dout;
            SEL_PIA: cpu_din_d = bus.pia_dout;
            default: cpu_din_d = OPEN_BUS;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q   <= '0;
            cpu_clken_q <= 1'b0;
            sel_q       <= SEL_NONE;
            cpu_din_q   <= 8'h00;
        end else begin
            div_cnt_q   <= div_cnt_d;
            cpu_clken_q <= cpu_clken_d;
            sel_q       <= sel_d;
            cpu_din_q   <= cpu_din_d;
        end
    end

    assign bus.cpu_clken = cpu_clken_q;
    assign bus.cpu_din   = cpu_din_q;

    assign bus.rom_addr  = bus.cpu_addr[7:0];
    assign bus.ram_addr  = bus.cpu_addr[RAM_AW-1:0];
    assign bus.ram_din   = bus.cpu_dout;
    assign bus.pia_rs    = bus.cpu_addr[1:0];
    assign bus.pia_din   = bus.cpu_dout;

    // Strobes use the current decode: the CPU only moves its address after the
    // enabled edge, so the pulse always belongs to the cycle that is ending.
    // pia_rd fires once per CPU read so the PIA clears keyboard-ready only once.
    assign bus.ram_we    = cpu_clken_q &  bus.cpu_we & (dec == SEL_RAM);
    assign bus.pia_we    = cpu_clken_q &  bus.cpu_we & (dec == SEL_PIA);
    assign bus.pia_rd    = cpu_clken_q & ~bus.cpu_we & (dec == SEL_PIA);
endmodule

// File: tb/tb_apple1_bus_ctrl.sv
// tb/tb_apple1_bus_ctrl.sv - scoreboard testbench for apple1_bus_ctrl
module tb_apple1_bus_ctrl;
    localparam int CLK_DIV = 25;
    localparam int RAM_AW  = 13;

    logic clk;
    logic rst_n;

    apple1_bus_ctrl_if #(.RAM_AW(RAM_AW)) bus_if ();

    apple1_bus_ctrl #(
        .CLK_DIV (CLK_DIV),
        .RAM_AW  (RAM_AW),
        .OPEN_BUS(8'hFF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Device models: every device answers one clk after its address.
    logic [7:0] ram_mem [0:(1<<RAM_AW)-1];

    always @(posedge clk) begin
        bus_if.rom_dout <= (bus_if.rom_addr == 8'h00) ? 8'hD8 : (bus_if.rom_addr ^ 8'hA5);
        if (bus_if.ram_we) ram_mem[bus_if.ram_addr] <= bus_if.ram_din;
        bus_if.ram_dout <= ram_mem[bus_if.ram_addr];
        case (bus_if.pia_rs)
            2'd0:    bus_if.pia_dout <= 8'h41;
            2'd1:    bus_if.pia_dout <= 8'h80;
            default: bus_if.pia_dout <= 8'h00;
        endcase
    end

    typedef struct {
        logic [15:0] addr;
        logic        chk_din;
        logic [7:0]  din;
        logic        rw;
        logic        pw;
        logic        pr;
        logic [7:0]  wd;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec;
    int   errs;
    bit   stim_done;

    task automatic fail_line(input string name, input int act, input int req);
        $display("FAIL %s: got %0h expected %0h", name, act, req);
        errs++;
    endtask

    task automatic check(input string name, input int act, input int req);
        if (act != req) fail_line(name, act, req);
    endtask

    // Monitor: pops one expectation per CPU clock enable; outside enables no strobe may be high.
    task automatic monitor_step();
        exp_t e;
        @(negedge clk);
        if (rst_n !== 1'b1) return;
        if (bus_if.cpu_clken) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk_din) check($sformatf("cpu_din@%04h", e.addr), bus_if.cpu_din, e.din);
                check($sformatf("ram_we@%04h", e.addr),   bus_if.ram_we,   e.rw);
                check($sformatf("pia_we@%04h", e.addr),   bus_if.pia_we,   e.pw);
                check($sformatf("pia_rd@%04h", e.addr),   bus_if.pia_rd,   e.pr);
                check($sformatf("rom_addr@%04h", e.addr), bus_if.rom_addr, e.addr[7:0]);
                check($sformatf("ram_addr@%04h", e.addr), bus_if.ram_addr, e.addr[RAM_AW-1:0]);
                check($sformatf("pia_rs@%04h", e.addr),   bus_if.pia_rs,   e.addr[1:0]);
                check($sformatf("ram_din@%04h", e.addr),  bus_if.ram_din,  e.wd);
                check($sformatf("pia_din@%04h", e.addr),  bus_if.pia_din,  e.wd);
            end
        end else if (bus_if.ram_we || bus_if.pia_we || bus_if.pia_rd) begin
            fail_line("strobe_outside_clken",
                      {29'd0, bus_if.ram_we, bus_if.pia_we, bus_if.pia_rd}, 0);
        end
    endtask

    task automatic wait_clken();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_if.cpu_clken && n < 4 * CLK_DIV);
        if (!bus_if.cpu_clken) fail_line("clken_timeout", n, CLK_DIV);
    endtask

    // Count posedges until cpu_clken is seen high just after one.
    task automatic measure_clken(input string name, input int req);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus_if.cpu_clken && n < 4 * CLK_DIV);
        check(name, n, req);
    endtask

    // Issue one CPU cycle right after an enabled edge, as the 6502 would.
    task automatic apply(input logic [15:0] addr, input logic we, input logic [7:0] dout,
                         input logic chk_din, input logic [7:0] din,
                         input logic rw, input logic pw, input logic pr);
        exp_t e;
        wait_clken();
        @(posedge clk);
        #1;
        bus_if.cpu_addr = addr;
        bus_if.cpu_we   = we;
        bus_if.cpu_dout = dout;
        e.addr = addr; e.chk_din = chk_din; e.din = din;
        e.rw = rw; e.pw = pw; e.pr = pr; e.wd = dout;
        exp_q.push_back(e);
        n_vec++;
    endtask

    task automatic stimulus();
        rst_n           = 1'b0;
        bus_if.cpu_addr = 16'h0000;
        bus_if.cpu_we   = 1'b0;
        bus_if.cpu_dout = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cpu_din", bus_if.cpu_din, 8'h00);
        check("reset_clken", bus_if.cpu_clken, 0);
        check("reset_ram_we", bus_if.ram_we, 0);

        // Released just after an edge: that clk period is the first, the pulse occupies the 25th.
        rst_n = 1'b1;
        measure_clken("first_clken_edges", CLK_DIV - 1);
        @(posedge clk);
        #1;
        check("clken_one_clk_wide", bus_if.cpu_clken, 0);
        measure_clken("clken_period_1", CLK_DIV - 1);
        measure_clken("clken_period_2", CLK_DIV);

        // ROM read with explicit two-clk latency check.
        apply(16'hFF00, 1'b0, 8'h00, 1'b1, 8'hD8, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rom_latency_2clk", bus_if.cpu_din, 8'hD8);
        apply(16'hFFFF, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        // RAM boundary.
        apply(16'h1FFF, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        apply(16'h1FFF, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        apply(16'h2000, 1'b1, 8'h5A, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        apply(16'h1000, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        apply(16'h1000, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        // PIA reads, mirror and write.
        apply(16'hD011, 1'b0, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1);
        apply(16'hD010, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 1'b0, 1'b1);
        apply(16'hD01D, 1'b0, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1);
        apply(16'hD012, 1'b1, 8'h33, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        // Unmapped read and write sweeps.
        apply(16'hD00F, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        apply(16'hD020, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        apply(16'hFEFF, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        apply(16'h8000, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        apply(16'hD00F, 1'b1, 8'hC3, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        apply(16'hD020, 1'b1, 8'hC3, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        apply(16'hFEFF, 1'b1, 8'hC3, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        apply(16'h8000, 1'b1, 8'hC3, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        apply(16'hFF00, 1'b1, 8'hC3, 1'b1, 8'hD8, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a RAM write cycle: the write must be lost.
        wait_clken();
        @(posedge clk);
        #1;
        bus_if.cpu_addr = 16'h1000;
        bus_if.cpu_we   = 1'b1;
        bus_if.cpu_dout = 8'h22;
        repeat (12) @(posedge clk);
        #1;
        rst_n         = 1'b0;
        bus_if.cpu_we = 1'b0;
        #1;
        check("midreset_cpu_din", bus_if.cpu_din, 8'h00);
        check("midreset_clken", bus_if.cpu_clken, 0);
        check("midreset_ram_we", bus_if.ram_we, 0);
        repeat (CLK_DIV) @(posedge clk);
        #1;
        check("midreset_hold_clken", bus_if.cpu_clken, 0);
        rst_n = 1'b1;
        measure_clken("post_reset_clken_edges", CLK_DIV - 1);
        bus_if.cpu_addr = 16'hFF00;
        apply(16'h1000, 1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        apply(16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        wait_clken();
        @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        n_vec = 0;
        errs  = 0;
        fork
            forever monitor_step();
            stimulus();
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/apple1_bus_ctrl.md
Name: apple1_bus_ctrl

Overview:
CPU-side bus controller that sits between the 6502 core and the memory and I/O stages: WozMon ROM, main RAM and the keyboard/display PIA. It generates the CPU clock enable and decodes the CPU address into device selects and write/read strobes. It also registers the returned read data so that synchronous, one-cycle-latency memories such as the registered ROM are aligned to the CPU sampling edge. All read data returned to the CPU passes through this block.

Parameters:
CLK_DIV, 25, clk cycles per CPU cycle; legal range >= 3.
RAM_AW, 13, RAM address width; RAM occupies $0000 to (2^RAM_AW - 1), and RAM_AW must be <= 15.
OPEN_BUS, 8'hFF, value returned for reads of unmapped addresses.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
cpu_addr  in  16  CPU address bus
cpu_we  in  1  CPU write flag; 1 = write
cpu_dout  in  8  CPU write data
cpu_din  out  8  registered read data to the CPU
cpu_clken  out  1  one-clk-wide CPU clock enable
rom_addr  out  8  ROM address, equal to cpu_addr[7:0]
rom_dout  in  8  ROM data, valid 1 clk after rom_addr
ram_addr  out  RAM_AW  RAM address, equal to cpu_addr[RAM_AW-1:0]
ram_din  out  8  RAM write data, equal to cpu_dout
ram_we  out  1  RAM write strobe
ram_dout  in  8  RAM data, valid 1 clk after ram_addr
pia_rs  out  2  PIA register select, equal to cpu_addr[1:0]
pia_din  out  8  PIA write data, equal to cpu_dout
pia_we  out  1  PIA write strobe
pia_rd  out  1  PIA read strobe; used by the PIA to clear its keyboard-ready flag
pia_dout  in  8  PIA read data, valid 1 clk after pia_rs

Behaviour:
- Reset: while rst_n is low, all registers clear asynchronously:
  - div_cnt = 0
  - cpu_clken = 0
  - sel_q = NONE
  - cpu_din = 8'h00
  - ram_we, pia_we and pia_rd are 0 (they are gated by cpu_clken)
- Divider:
  - div_cnt counts 0 to CLK_DIV-1 and then wraps to 0.
  - cpu_clken is registered; it is 1 for exactly the one clk in which div_cnt == CLK_DIV-1, otherwise 0.
  - The first pulse occurs CLK_DIV clks after reset release.
- Decode is combinational from cpu_addr, with mutually exclusive regions:
  - RAM: cpu_addr < 2^RAM_AW
  - PIA: cpu_addr[15:4] == 12'hD01, i.e. $D010 to $D01F; registers are mirrored every 4 bytes
  - ROM: cpu_addr[15:8] == 8'hFF
  - NONE: every other address
- Select register:
  - sel_q is updated to the current decode on every clk.
  - This aligns sel_q with the one-clk device latency.
- Read path:
  - cpu_din is updated every clk with the source chosen by sel_q:
    - RAM selects ram_dout
    - ROM selects rom_dout
    - PIA selects pia_dout
    - NONE selects OPEN_BUS
  - Total latency from address to cpu_din is 2 clks.
  - The CPU address is stable from the clk after a cpu_clken pulse. cpu_din is therefore valid from div_cnt == 2 onward, which is before the next pulse given CLK_DIV >= 3.
- Write strobes:
  - ram_we = cpu_clken & cpu_we & sel_ram
  - pia_we = cpu_clken & cpu_we & sel_pia
  - Both are combinational from the current decode and are exactly 1 clk wide.
  - Writes to ROM and NONE regions are dropped and produce no strobe.
- pia_rd = cpu_clken & ~cpu_we & sel_pia. It fires exactly once per CPU read cycle, even though cpu_din is sampled many clks earlier.
- Address and data pass-throughs (rom_addr, ram_addr, ram_din, pia_rs, pia_din) are combinational and ungated.
- Simultaneous events: on a clk where cpu_clken is 1 and cpu_addr changes, the strobes use the pre-change address. The CPU core changes its address only after the enabled edge.
- Reset mid-operation: the divider restarts at 0 and no strobe is emitted while rst_n is low. A write in progress is discarded.
- Boundary checks:
  - Address $1FFF (RAM_AW = 13) is RAM; $2000 is NONE.
  - $D00F is NONE; $D010 is PIA; $D020 is NONE.
  - $FEFF is NONE; $FF00 is ROM.

Test Plan:
- Reset, then release with CLK_DIV=25 -> cpu_clken first high 25 clks after release; thereafter exactly 1 clk high every 25 clks; cpu_din = 00 during reset.
- Hold cpu_addr=$FF00, cpu_we=0, ROM model returns 8'hD8 one clk late -> cpu_din = D8 two clks after the address is applied, stable at the next cpu_clken; ram_we, pia_we and pia_rd stay 0.
- cpu_addr=$1FFF, cpu_we=1, cpu_dout=8'h5A -> ram_we pulses 1 clk coincident with cpu_clken, ram_addr=1FFF, ram_din=5A; cpu_addr=$2000 with the same stimulus -> no ram_we pulse.
- cpu_addr=$D011, cpu_we=0, PIA returns 8'h80 -> pia_rs=1, cpu_din=80, pia_rd exactly one pulse per CPU cycle; cpu_addr=$D012, cpu_we=1 -> pia_we pulse, pia_rs=2.
- Read sweep of $D00F, $D020, $FEFF, $8000 -> cpu_din = FF for each; write sweep of the same addresses -> no write strobes.
- Assert rst_n low at div_cnt=12 during a RAM write cycle -> no ram_we pulse; after release, the next cpu_clken comes 25 clks later.
